tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
- Upstream control stage for the shared tri-state bus. It produces the per-driver output-enable (oe) lines that gate each tristate buffer instance onto the common wire.
- Arbitrates N requesters round-robin, enforces a maximum tenure per grant, and inserts a turnaround gap (all oe low) between owners so two drivers never overlap on the bus.

Parameters:
- N_MASTERS, 4, number of requesters/tristate drivers; legal range is 2 or more.
- MAX_HOLD, 8, maximum consecutive cycles one master may keep oe asserted; legal range is 1 or more.
- TURNAROUND, 1, number of cycles with all oe low between any two grants; legal range is 1 or more.
- OW, $clog2(N_MASTERS), width of the owner index (derived; do not override).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_MASTERS  per-master bus request, level-sensitive, sampled at rising edge.
- oe  output  N_MASTERS  per-master tristate enable; registered; one-hot or zero.
- owner  output  OW  index of the current or last bus owner; registered.
- bus_busy  output  1  high when any oe bit is set (OR of oe), registered.
- in_turn  output  1  high during turnaround cycles; registered.

Behaviour:
- Reset (rst_n low, asynchronous): oe=0, owner=0, bus_busy=0, in_turn=0, state=IDLE, hold_cnt=0, turn_cnt=0, last_owner=N_MASTERS-1 (so master 0 has first priority). All oe bits fall immediately on rst_n assertion, including mid-grant; there is no drain.
- States: IDLE, GRANT, TURN.
- IDLE: oe=0.
  - At an edge where req!=0: pick the first set bit scanning (last_owner+1) mod N upward with wrap.
  - Then set oe to that bit, owner to the pick, hold_cnt=1, state=GRANT.
  - Latency: req sampled high at edge k gives oe high from edge k (visible after clk-to-q), i.e. 1-cycle registered response.
- GRANT: exactly one oe bit set.
  - At each edge, if req[owner]==0 or hold_cnt==MAX_HOLD: oe=0, last_owner=owner, in_turn=1, turn_cnt=1, state=TURN.
  - Otherwise hold_cnt increments and oe is unchanged.
  - Consequence: oe is high for at most MAX_HOLD consecutive cycles.
- TURN: oe=0, in_turn=1.
  - If turn_cnt<TURNAROUND: increment turn_cnt.
  - On the edge where turn_cnt==TURNAROUND: arbitrate exactly as in IDLE. A grant issues directly if req!=0; otherwise in_turn=0 and state=IDLE.
  - Gap between owners is therefore exactly TURNAROUND cycles.
- Fairness: the master released by timeout or by dropping req becomes lowest priority. The sole requester is re-granted after the gap.
- Simultaneous events:
  - Requests from other masters during GRANT do not preempt.
  - req[owner] dropping on the same edge that hold_cnt reaches MAX_HOLD releases the bus once (single transition to TURN).
  - Requests arriving during TURN are considered at the TURN exit edge.
- owner holds its value through TURN and IDLE. bus_busy equals |oe at all times.
- Invariant, checked by assertion: $onehot0(oe) every cycle, and oe is never nonzero while in_turn==1.

Test Plan:
- Reset then single requester (defaults N=4, MAX_HOLD=8, TURNAROUND=1): req=0001 held continuously -> oe=0001 for 8 cycles, 1 cycle oe=0000 with in_turn=1, then oe=0001 again; owner=0 throughout.
- Round-robin rotation: req=1111 from reset -> grants in order 0,1,2,3,0 with owner=0,1,2,3,0; each tenure is 8 cycles, separated by 1 zero cycle.
- Early release: req=0100 for 3 cycles then 0 -> oe=0100 for exactly 3 cycles, one turn cycle, then IDLE with bus_busy=0 and owner=2.
- Turnaround parameter: TURNAROUND=3, req=0011 -> master 0 granted; after release, oe=0000 for exactly 3 cycles, then oe=0010.
- Reset mid-operation: assert rst_n low asynchronously (between clock edges) during a grant with oe=0010 -> oe=0000 immediately, before the next edge. After release with req=1111, first grant is oe=0001.
- Late arrival during turn: master 1 releases, and req[3] rises during the TURN cycle -> oe=1000 on the TURN exit edge with no extra IDLE cycle; the one-hot and no-overlap assertions hold for all cycles.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin output-enable controller for a shared tri-state bus.
// Grants one driver at a time, limits each tenure to MAX_HOLD cycles and
// forces TURNAROUND idle cycles (all oe low) between consecutive owners.
module tristate_bus_arbiter #(
    parameter int N_MASTERS  = 4,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1,
    parameter int OW         = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] oe,
    output logic [OW-1:0]        owner,
    output logic                 bus_busy,
    output logic                 in_turn
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LIMIT = TW'(TURNAROUND);
    localparam logic [OW-1:0] LAST_INIT  = OW'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]          turn_cnt_q, turn_cnt_d;
    logic [OW-1:0]          last_owner_q, last_owner_d;
    logic [N_MASTERS-1:0]   oe_d;
    logic [OW-1:0]          owner_d;
    logic                   in_turn_d;
    logic [OW-1:0]          pick;
    logic                   any_req;

    // First requester found scanning upward from the one after `last`,
    // wrapping around, so the previous owner ends up with lowest priority.
    function automatic logic [OW-1:0] rr_pick(input logic [N_MASTERS-1:0] r,
                                              input logic [OW-1:0]        last);
        logic [OW-1:0] sel;
        logic [OW-1:0] cand;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx  = (int'(last) + i) % N_MASTERS;
            cand = OW'(idx);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [N_MASTERS-1:0] to_onehot(input logic [OW-1:0] i);
        logic [N_MASTERS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign pick    = rr_pick(req, last_owner_q);
    assign any_req = |req;

    // Next-state and next-output decode for the IDLE/GRANT/TURN controller.
    always_comb begin
        state_d      = state_q;
        oe_d         = oe;
        owner_d      = owner;
        in_turn_d    = in_turn;
        hold_cnt_d   = hold_cnt_q;
        turn_cnt_d   = turn_cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            IDLE: begin
                oe_d      = '0;
                in_turn_d = 1'b0;
                if (any_req) begin
                    oe_d       = to_onehot(pick);
                    owner_d    = pick;
                    hold_cnt_d = HW'(1);
                    state_d    = GRANT;
                end
            end

            GRANT: begin
                // Other requesters never preempt; only the owner dropping
                // its request or the tenure limit ends the grant.
                if (!req[owner] || (hold_cnt_q == HOLD_LIMIT)) begin
                    oe_d         = '0;
                    last_owner_d = owner;
                    in_turn_d    = 1'b1;
                    turn_cnt_d   = TW'(1);
                    state_d      = TURN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            TURN: begin
                oe_d      = '0;
                in_turn_d = 1'b1;
                if (turn_cnt_q < TURN_LIMIT) begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end else begin
                    // Gap complete: hand the bus straight to the next
                    // requester, or fall back to IDLE if nobody wants it.
                    in_turn_d = 1'b0;
                    if (any_req) begin
                        oe_d       = to_onehot(pick);
                        owner_d    = pick;
                        hold_cnt_d = HW'(1);
                        state_d    = GRANT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                oe_d      = '0;
                in_turn_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops every oe line immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            turn_cnt_q   <= '0;
            last_owner_q <= LAST_INIT;
            oe           <= '0;
            owner        <= '0;
            bus_busy     <= 1'b0;
            in_turn      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            turn_cnt_q   <= turn_cnt_d;
            last_owner_q <= last_owner_d;
            oe           <= oe_d;
            owner        <= owner_d;
            bus_busy     <= |oe_d;
            in_turn      <= in_turn_d;
        end
    end

    // Two drivers must never be enabled together, and none during a gap.
    a_oe_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
                                   $onehot0(oe));
    a_no_oe_in_turn: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(in_turn && (oe != '0)));

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: a default instance and a
// TURNAROUND=3 instance driven by directed vectors with hand-worked results.
module tb_tristate_bus_arbiter;

    localparam int N  = 4;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_a, req_b;
    logic [N-1:0]  oe_a, oe_b;
    logic [OW-1:0] owner_a, owner_b;
    logic          busy_a, busy_b;
    logic          turn_a, turn_b;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.N_MASTERS(N), .MAX_HOLD(8), .TURNAROUND(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .oe(oe_a), .owner(owner_a), .bus_busy(busy_a), .in_turn(turn_a)
    );

    tristate_bus_arbiter #(.N_MASTERS(N), .MAX_HOLD(8), .TURNAROUND(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .oe(oe_b), .owner(owner_b), .bus_busy(busy_b), .in_turn(turn_b)
    );

    typedef struct {
        string         tag;
        logic [N-1:0]  oe;
        logic [OW-1:0] owner;
        logic          busy;
        logic          turn;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string name, input exp_t e,
                           input logic [N-1:0] o, input logic [OW-1:0] w,
                           input logic b, input logic t);
        checks++;
        if (o !== e.oe || w !== e.owner || b !== e.busy || t !== e.turn) begin
            errors++;
            $display("FAIL %s: got oe=%b owner=%0d busy=%b in_turn=%b, expected oe=%b owner=%0d busy=%b in_turn=%b",
                     name, o, w, b, t, e.oe, e.owner, e.busy, e.turn);
        end
    endtask

    // Monitors: each queued expectation belongs to the next rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp_out({e.tag, " (dut_a)"}, e, oe_a, owner_a, busy_a, turn_a);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp_out({e.tag, " (dut_b)"}, e, oe_b, owner_b, busy_b, turn_b);
        end
    end

    // Safety invariant sampled every cycle on both instances.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("onehot0 dut_a", 32'($onehot0(oe_a)), 32'd1);
            chk("no oe in turn dut_a", 32'(turn_a && (oe_a != '0)), 32'd0);
            chk("onehot0 dut_b", 32'($onehot0(oe_b)), 32'd1);
            chk("no oe in turn dut_b", 32'(turn_b && (oe_b != '0)), 32'd0);
        end
    end

    task automatic step_a(input string tag, input int r, input int o, input int w,
                          input int b, input int t);
        exp_t e;
        @(negedge clk);
        req_a   = r[N-1:0];
        e.tag   = tag;
        e.oe    = o[N-1:0];
        e.owner = w[OW-1:0];
        e.busy  = b[0];
        e.turn  = t[0];
        qa.push_back(e);
    endtask

    task automatic step_b(input string tag, input int r, input int o, input int w,
                          input int b, input int t);
        exp_t e;
        @(negedge clk);
        req_b   = r[N-1:0];
        e.tag   = tag;
        e.oe    = o[N-1:0];
        e.owner = w[OW-1:0];
        e.busy  = b[0];
        e.turn  = t[0];
        qb.push_back(e);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        @(posedge clk);
        #1;
        chk("reset oe_a", 32'(oe_a), 32'd0);
        chk("reset owner_a", 32'(owner_a), 32'd0);
        chk("reset busy_a", 32'(busy_a), 32'd0);
        chk("reset in_turn_a", 32'(turn_a), 32'd0);
        chk("reset oe_b", 32'(oe_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sole requester: 8-cycle tenure, one gap cycle, re-granted.
        for (int i = 0; i < 8; i++) step_a("single hold", 1, 1, 0, 1, 0);
        step_a("single gap", 1, 0, 0, 0, 1);
        step_a("single regrant", 1, 1, 0, 1, 0);
        step_a("single release", 0, 0, 0, 0, 1);
        step_a("single idle", 0, 0, 0, 0, 0);

        // Round robin from reset with all four requesting.
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) step_a("rr tenure", 15, 1 << (k % 4), k % 4, 1, 0);
            if (k < 4) step_a("rr gap", 15, 0, k % 4, 0, 1);
        end
        step_a("rr final release", 0, 0, 0, 0, 1);
        step_a("rr idle", 0, 0, 0, 0, 0);

        // Early release by master 2 after three cycles.
        for (int i = 0; i < 3; i++) step_a("early grant", 4, 4, 2, 1, 0);
        step_a("early turn", 0, 0, 2, 0, 1);
        step_a("early idle", 0, 0, 2, 0, 0);

        // Master 1 releases; master 3 arrives during the turn cycle.
        step_a("late m1 grant", 2, 2, 1, 1, 0);
        step_a("late m1 grant", 2, 2, 1, 1, 0);
        step_a("late turn", 0, 0, 1, 0, 1);
        step_a("late m3 grant", 8, 8, 3, 1, 0);
        step_a("late m3 release", 0, 0, 3, 0, 1);
        step_a("late idle", 0, 0, 3, 0, 0);

        // Request drop coincides with the tenure limit: one release only.
        for (int i = 0; i < 8; i++) step_a("coincide hold", 1, 1, 0, 1, 0);
        step_a("coincide turn", 0, 0, 0, 0, 1);
        step_a("coincide idle", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a grant to master 1.
        step_a("midreset grant", 2, 2, 1, 1, 0);
        step_a("midreset grant", 2, 2, 1, 1, 0);
        @(posedge clk);
        #2;
        chk("midreset oe before", 32'(oe_a), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset oe async", 32'(oe_a), 32'd0);
        chk("midreset busy async", 32'(busy_a), 32'd0);
        chk("midreset owner async", 32'(owner_a), 32'd0);
        @(negedge clk);
        req_a = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        step_a("post reset grant m0", 15, 1, 0, 1, 0);
        step_a("post reset grant m0", 15, 1, 0, 1, 0);
        step_a("post reset release", 0, 0, 0, 0, 1);
        step_a("post reset idle", 0, 0, 0, 0, 0);

        // TURNAROUND=3 instance: exactly three idle cycles between owners.
        for (int i = 0; i < 8; i++) step_b("ta3 m0 tenure", 3, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step_b("ta3 gap", 3, 0, 0, 0, 1);
        step_b("ta3 m1 grant", 3, 2, 1, 1, 0);
        for (int i = 0; i < 3; i++) step_b("ta3 release gap", 0, 0, 1, 0, 1);
        step_b("ta3 idle", 0, 0, 1, 0, 0);

        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
